// File: rtl/autosa_rubik_rd_cdt_ctrl.sv
// Rubik DMA read-path sequencer: splits a transfer into 512-bit line requests and
// only issues while a dr2drc response-FIFO credit is free, returning to IDLE after every credit comes back.
module autosa_rubik_rd_cdt_ctrl #(
    parameter int AW        = 64,
    parameter int CDT_DEPTH = 8,
    parameter int CW        = 8
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rstn,
    input  logic          op_en,
    input  logic [AW-1:0] cfg_base_addr,
    input  logic [15:0]   cfg_half_cnt,
    output logic          rd_req_vld,
    input  logic          rd_req_rdy,
    output logic [AW-1:0] rd_req_addr,
    output logic [1:0]    rd_req_mask,
    input  logic          rd_cdt_lat_fifo_pop,
    output logic          op_done,
    output logic          busy,
    output logic [CW-1:0] cdt_cnt,
    output logic          cdt_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   left_q, left_d;
    logic          odd_q, odd_d;
    logic [CW-1:0] cdt_q, cdt_d;
    logic          err_q, err_d;

    logic issue;
    logic last;
    logic cdt_full;

    assign last     = (left_q == 16'd1);
    assign cdt_full = (cdt_q == CW'(CDT_DEPTH));

    // Outputs decode registered state only; credits never drop without a handshake,
    // so a raised valid is held until accepted.
    assign rd_req_vld  = (state_q == REQ) && (cdt_q != '0);
    assign rd_req_addr = addr_q;
    assign rd_req_mask = (state_q != REQ) ? 2'b00 :
                         (last && odd_q)  ? 2'b01 : 2'b11;
    assign op_done     = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign cdt_cnt     = cdt_q;
    assign cdt_err     = err_q;

    assign issue = rd_req_vld & rd_req_rdy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        odd_d   = odd_q;
        cdt_d   = cdt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (op_en) begin
                    addr_d  = cfg_base_addr;
                    left_d  = (cfg_half_cnt >> 1) + 16'(cfg_half_cnt[0]);
                    odd_d   = cfg_half_cnt[0];
                    state_d = (cfg_half_cnt != 16'd0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (issue) begin
                    addr_d = addr_q + AW'(64);
                    left_d = left_q - 16'd1;
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cdt_full) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pops are honoured in every state; one that would overfill the pool is dropped and flagged.
        case ({issue, rd_cdt_lat_fifo_pop})
            2'b10: cdt_d = cdt_q - CW'(1);
            2'b01: begin
                if (cdt_full) begin
                    err_d = 1'b1;
                end else begin
                    cdt_d = cdt_q + CW'(1);
                end
            end
            default: cdt_d = cdt_q;
        endcase
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            odd_q   <= 1'b0;
            cdt_q   <= CW'(CDT_DEPTH);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            odd_q   <= odd_d;
            cdt_q   <= cdt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_autosa_rubik_rd_cdt_ctrl.sv
// Bench for autosa_rubik_rd_cdt_ctrl: request-list / credit-pool model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_autosa_rubik_rd_cdt_ctrl;

    localparam int AW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          clk;
    logic          rstn;
    logic          op_en;
    logic [AW-1:0] cfg_base_addr;
    logic [15:0]   cfg_half_cnt;
    logic          rd_req_vld;
    logic          rd_req_rdy;
    logic [AW-1:0] rd_req_addr;
    logic [1:0]    rd_req_mask;
    logic          pop;
    logic          op_done;
    logic          busy;
    logic [CW-1:0] cdt_cnt;
    logic          cdt_err;

    autosa_rubik_rd_cdt_ctrl #(.AW(AW), .CDT_DEPTH(DEPTH), .CW(CW)) dut (
        .autosa_core_clk     (clk),
        .autosa_core_rstn    (rstn),
        .op_en               (op_en),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_half_cnt        (cfg_half_cnt),
        .rd_req_vld          (rd_req_vld),
        .rd_req_rdy          (rd_req_rdy),
        .rd_req_addr         (rd_req_addr),
        .rd_req_mask         (rd_req_mask),
        .rd_cdt_lat_fifo_pop (pop),
        .op_done             (op_done),
        .busy                (busy),
        .cdt_cnt             (cdt_cnt),
        .cdt_err             (cdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the transfer is a list of pending line requests plus a credit pool.
    typedef struct packed {
        logic [63:0] a;
        logic [1:0]  m;
    } req_t;

    req_t        pend[$];
    int          cred_m;
    bit          err_m;
    bit          busy_m;
    bit          done_m;
    int          hs_cnt;
    int          done_cnt;
    logic [63:0] hs_addr[$];
    logic [1:0]  hs_mask[$];

    function automatic void model_reset();
        pend.delete();
        cred_m = DEPTH;
        err_m  = 1'b0;
        busy_m = 1'b0;
        done_m = 1'b0;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        bit exp_vld;
        bit iss;
        if (!rstn) begin
            model_reset();
            chk("rst_vld", rd_req_vld, 0);
            chk("rst_addr", rd_req_addr, 0);
            chk("rst_mask", rd_req_mask, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", op_done, 0);
            chk("rst_cdt", cdt_cnt, DEPTH);
            chk("rst_err", cdt_err, 0);
        end else begin
            exp_vld = busy_m && !done_m && (pend.size() > 0) && (cred_m > 0);
            chk("vld", rd_req_vld, exp_vld);
            chk("busy", busy, busy_m);
            chk("op_done", op_done, done_m);
            chk("cdt_cnt", cdt_cnt, cred_m);
            chk("cdt_err", cdt_err, err_m);
            if (exp_vld) begin
                chk("addr", rd_req_addr, pend[0].a);
                chk("mask", rd_req_mask, pend[0].m);
            end
            if (rd_req_vld && rd_req_rdy) begin
                hs_cnt++;
                hs_addr.push_back(rd_req_addr);
                hs_mask.push_back(rd_req_mask);
            end
            if (op_done) done_cnt++;

            iss = exp_vld && rd_req_rdy;
            if (done_m) begin
                done_m = 1'b0;
                busy_m = 1'b0;
            end else if (busy_m) begin
                if (pend.size() == 0 && cred_m == DEPTH) done_m = 1'b1;
                if (iss) void'(pend.pop_front());
            end else if (op_en) begin
                int n;
                n = (int'(cfg_half_cnt) + 1) / 2;
                for (int i = 0; i < n; i++) begin
                    req_t r;
                    r.a = cfg_base_addr + 64'(64 * i);
                    r.m = (i == n - 1 && cfg_half_cnt[0]) ? 2'b01 : 2'b11;
                    pend.push_back(r);
                end
                busy_m = 1'b1;
                done_m = (cfg_half_cnt == 16'd0);
            end
            if (iss && !pop)            cred_m = cred_m - 1;
            else if (!iss && pop) begin
                if (cred_m == DEPTH)    err_m = 1'b1;
                else                    cred_m = cred_m + 1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] base, input logic [15:0] half, input logic rdy);
        cfg_base_addr = base;
        cfg_half_cnt  = half;
        rd_req_rdy    = rdy;
        op_en         = 1'b1;
        cycle();
        op_en = 1'b0;
    endtask

    task automatic finish_xfer(input bit spam);
        int n;
        n = 0;
        while (busy_m && n < 3000) begin
            rd_req_rdy = ($urandom % 4) != 0;
            pop        = (cred_m < DEPTH) && (($urandom % 3) == 0);
            if (spam) begin
                op_en         = ($urandom % 6) == 0;
                cfg_half_cnt  = 16'($urandom_range(0, 24));
                cfg_base_addr = {$urandom, $urandom} & ~64'h3f;
            end
            cycle();
            n++;
        end
        op_en      = 1'b0;
        pop        = 1'b0;
        rd_req_rdy = 1'b0;
        @(negedge clk);
        chk("xfer_end_busy", busy, 0);
        cycle();
    endtask

    initial begin
        logic [63:0] hold_addr;
        logic [1:0]  hold_mask;
        int          base_hs;
        rstn = 1'b0; op_en = 1'b0; cfg_base_addr = '0; cfg_half_cnt = '0;
        rd_req_rdy = 1'b0; pop = 1'b0;
        hs_cnt = 0; done_cnt = 0;
        repeat (3) cycle();
        rstn = 1'b1;
        cycle();

        // Odd-length transfer: 5 halves -> 3 lines, last one lower-half only.
        start(64'h1000, 16'd5, 1'b1);
        repeat (8) cycle();
        @(negedge clk);
        chk("odd_hs", hs_cnt, 3);
        if (hs_addr.size() == 3) begin
            chk("odd_a0", hs_addr[0], 64'h1000);
            chk("odd_a1", hs_addr[1], 64'h1040);
            chk("odd_a2", hs_addr[2], 64'h1080);
            chk("odd_m0", hs_mask[0], 2'b11);
            chk("odd_m1", hs_mask[1], 2'b11);
            chk("odd_m2", hs_mask[2], 2'b01);
        end
        chk("odd_cdt", cdt_cnt, 5);
        chk("odd_busy", busy, 1);
        chk("odd_nodone", done_cnt, 0);

        // Credit return.
        rd_req_rdy = 1'b0;
        pop = 1'b1;
        repeat (3) cycle();
        pop = 1'b0;
        @(negedge clk);
        chk("ret_cdt", cdt_cnt, DEPTH);
        chk("ret_done_not_yet", op_done, 0);
        cycle();
        @(negedge clk);
        chk("ret_done", op_done, 1);
        cycle();
        @(negedge clk);
        chk("ret_done_cnt", done_cnt, 1);
        chk("ret_idle", busy, 0);

        // Credit exhaustion: 10 lines, 8 credits, no pops.
        hs_cnt = 0;
        start(64'h2000, 16'd20, 1'b1);
        repeat (14) cycle();
        @(negedge clk);
        chk("exh_hs", hs_cnt, DEPTH);
        chk("exh_cdt", cdt_cnt, 0);
        chk("exh_vld", rd_req_vld, 0);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        repeat (4) cycle();
        @(negedge clk);
        chk("exh_one_more", hs_cnt, DEPTH + 1);

        // Backpressure: return one credit with rdy low, hold 4 cycles.
        rd_req_rdy = 1'b0;
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        @(negedge clk);
        hold_addr = rd_req_addr;
        hold_mask = rd_req_mask;
        chk("bp_vld", rd_req_vld, 1);
        chk("bp_addr_first", hold_addr, 64'h2240);
        for (int i = 0; i < 4; i++) begin
            cycle();
            @(negedge clk);
            chk("bp_addr", rd_req_addr, hold_addr);
            chk("bp_mask", rd_req_mask, hold_mask);
            chk("bp_cdt", cdt_cnt, 1);
        end
        rd_req_rdy = 1'b1;
        cycle();
        rd_req_rdy = 1'b0;
        @(negedge clk);
        chk("bp_hs", hs_cnt, DEPTH + 2);
        finish_xfer(1'b0);

        // Simultaneous issue and pop at cdt_cnt == 3.
        hs_cnt = 0;
        start(64'h4000, 16'd20, 1'b0);
        rd_req_rdy = 1'b1;
        repeat (5) cycle();
        pop = 1'b1;
        @(negedge clk);
        chk("sim_cdt_before", cdt_cnt, 3);
        chk("sim_vld", rd_req_vld, 1);
        cycle();
        pop = 1'b0;
        rd_req_rdy = 1'b0;
        @(negedge clk);
        chk("sim_cdt_after", cdt_cnt, 3);
        chk("sim_hs", hs_cnt, 6);
        finish_xfer(1'b0);

        // Zero-length transfer.
        hs_cnt = 0;
        start(64'h8000, 16'd0, 1'b1);
        @(negedge clk);
        chk("zero_done", op_done, 1);
        cycle();
        @(negedge clk);
        chk("zero_done_low", op_done, 0);
        chk("zero_idle", busy, 0);
        chk("zero_no_req", hs_cnt, 0);
        rd_req_rdy = 1'b0;

        // Randomized transfers, op_en spammed while busy.
        for (int t = 0; t < 40; t++) begin
            start({$urandom, $urandom} & ~64'h3f, 16'($urandom_range(0, 24)), $urandom % 2);
            finish_xfer(1'b1);
        end

        // Overflowing pop at a full pool.
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        @(negedge clk);
        chk("ovf_cdt", cdt_cnt, DEPTH);
        chk("ovf_err", cdt_err, 1);
        repeat (3) cycle();
        @(negedge clk);
        chk("ovf_err_sticky", cdt_err, 1);

        // Reset in the middle of a transfer.
        start(64'hA000, 16'd20, 1'b1);
        repeat (3) cycle();
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", rd_req_vld, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cdt", cdt_cnt, DEPTH);
        chk("mid_rst_err", cdt_err, 0);
        chk("mid_rst_addr", rd_req_addr, 0);
        cycle();
        rstn = 1'b1;
        rd_req_rdy = 1'b0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
